mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-input round-robin arbiter driving a registered 4:1 mux.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   req    : per-input ownership request, bit n requests mux input i[n]
//   i      : mux data inputs
//   grant  : one-hot grant, all-zero when idle
//   sel    : index of the granted input, holds its last value while idle
//   busy   : high while a grant is active
//   y      : registered mux output, loads i[sel] on every edge where busy=1
//
// Parameter
//   HOLD_MAX : maximum consecutive grant cycles per owner (2..15); only used
//              when the macro MUX_RR_HOLD_LIMIT_EN is defined.
//
// Macro MUX_RR_HOLD_LIMIT_EN adds a hold counter that forces a release after
// HOLD_MAX cycles when another input is waiting. Without it a grant lasts
// until its request drops.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no grant active, waiting for any request
// ST_GRANT| exactly one grant bit high, owner is sel
module mux_rr_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] i,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy,
   output logic       y
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] grant_q, grant_d;
   logic       busy_q, busy_d;
   logic       y_q, y_d;
   logic       hold_expired;

   logic [1:0] srch_base;
   logic [3:0] srch_req;
   logic [1:0] srch_cand;
   logic [1:0] srch_idx;
   logic       srch_found;

`ifdef MUX_RR_HOLD_LIMIT_EN
   logic [3:0] hold_q, hold_d;

   assign hold_expired = (hold_q == 4'(HOLD_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_q <= 4'd0;
      else     hold_q <= hold_d;
   end
`else
   assign hold_expired = 1'b0;
`endif

   // In GRANT the search starts just after the current owner and never picks
   // the owner itself, which covers both a normal release and a forced one.
   assign srch_base = (state_q == ST_GRANT) ? sel_q + 2'd1 : ptr_q;
   assign srch_req  = req & ~grant_q;

   always_comb begin
      srch_found = 1'b0;
      srch_idx   = srch_base;
      srch_cand  = srch_base;
      for (int k = 0; k < 4; k++) begin
         srch_cand = srch_base + 2'(k);
         if (!srch_found && srch_req[srch_cand]) begin
            srch_found = 1'b1;
            srch_idx   = srch_cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         grant_q <= 4'b0000;
         busy_q  <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         y_q     <= y_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      y_d     = busy_q ? i[sel_q] : y_q;
`ifdef MUX_RR_HOLD_LIMIT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (srch_found) begin
               state_d = ST_GRANT;
               grant_d = 4'b0001 << srch_idx;
               sel_d   = srch_idx;
               busy_d  = 1'b1;
`ifdef MUX_RR_HOLD_LIMIT_EN
               hold_d  = 4'd0;
`endif
            end
         end
         ST_GRANT: begin
`ifdef MUX_RR_HOLD_LIMIT_EN
            hold_d = hold_q + 4'd1;
`endif
            if (!req[sel_q] || (hold_expired && srch_found)) begin
               ptr_d = sel_q + 2'd1;
               if (srch_found) begin
                  grant_d = 4'b0001 << srch_idx;
                  sel_d   = srch_idx;
`ifdef MUX_RR_HOLD_LIMIT_EN
                  hold_d  = 4'd0;
`endif
               end else begin
                  state_d = ST_IDLE;
                  grant_d = 4'b0000;
                  busy_d  = 1'b0;
               end
            end else if (hold_expired) begin
               // Nobody else waiting: keep the owner and restart its window.
`ifdef MUX_RR_HOLD_LIMIT_EN
               hold_d = 4'd0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      grant = grant_q;
      sel   = sel_q;
      busy  = busy_q;
      y     = y_q;
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] i;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       y;

   int checks = 0;
   int errors = 0;

   mux_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .i     (i),
      .grant (grant),
      .sel   (sel),
      .busy  (busy),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] i;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       y;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_g;
      // Each entry: inputs applied before an edge, outputs expected after it.
      vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[2]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
      vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
      vecs[4]  = '{4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
      vecs[5]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[6]  = '{4'b1011, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b1};
      vecs[7]  = '{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[8]  = '{4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1};
      vecs[9]  = '{4'b1110, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b1};
      vecs[10] = '{4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};

      rst = 1'b0;
      req = 4'b0000;
      i   = 4'b0000;
      #1 rst = 1'b1;
      #1;
      check("reset grant", grant, 4'b0000);
      check("reset sel", {2'b00, sel}, 4'd0);
      check("reset busy", {3'b000, busy}, 4'd0);
      check("reset y", {3'b000, y}, 4'd0);
      step();
      step();
      rst = 1'b0;

      for (int n = 0; n < 11; n++) begin
         req = vecs[n].req;
         i   = vecs[n].i;
         step();
         check($sformatf("vec%0d grant", n), grant, vecs[n].grant);
         check($sformatf("vec%0d sel", n), {2'b00, sel}, {2'b00, vecs[n].sel});
         check($sformatf("vec%0d busy", n), {3'b000, busy}, {3'b000, vecs[n].busy});
         check($sformatf("vec%0d y", n), {3'b000, y}, {3'b000, vecs[n].y});
      end

      // Asynchronous reset while input 2 owns the mux and y=1.
      req = 4'b0000;
      step();
      check("pre-reset idle", grant, 4'b0000);
      req = 4'b0100;
      i   = 4'b0100;
      step();
      check("pre-reset grant", grant, 4'b0100);
      step();
      check("pre-reset y", {3'b000, y}, 4'd1);
      #2 rst = 1'b1;
      #1;
      check("async rst grant", grant, 4'b0000);
      check("async rst busy", {3'b000, busy}, 4'd0);
      check("async rst sel", {2'b00, sel}, 4'd0);
      check("async rst y", {3'b000, y}, 4'd0);
      req = 4'b1111;
      i   = 4'b0000;
      #2 rst = 1'b0;
      step();
      check("post-reset all req grant", grant, 4'b0001);
      check("post-reset all req sel", {2'b00, sel}, 4'd0);

      // All requesting: each owner keeps 3 cycles then drops for one cycle.
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 2; c++) begin
            req = 4'b1111;
            step();
            check($sformatf("rr owner%0d hold", k), grant, 4'b0001 << k);
            check($sformatf("rr owner%0d busy", k), {3'b000, busy}, 4'd1);
         end
         req = 4'b1111 & ~(4'b0001 << k);
         step();
         check($sformatf("rr handoff from %0d", k), grant, 4'b0001 << ((k + 1) % 4));
         check($sformatf("rr handoff busy %0d", k), {3'b000, busy}, 4'd1);
         check($sformatf("rr handoff sel %0d", k), {2'b00, sel}, 4'((k + 1) % 4));
      end

      // req=0011 held for 20 edges; input 0 was just granted.
      req = 4'b0011;
      for (int n = 1; n <= 20; n++) begin
         step();
`ifdef MUX_RR_HOLD_LIMIT_EN
         exp_g = ((n / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
         exp_g = 4'b0001;
`endif
         check($sformatf("req0011 edge%0d", n), grant, exp_g);
      end

`ifdef MUX_RR_HOLD_LIMIT_EN
      // Lone requester is never forced off.
      req = 4'b0001;
      for (int n = 0; n < 13; n++) begin
         step();
         check($sformatf("lone req edge%0d", n), grant, 4'b0001);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
